// File: rtl/uart_pkg.sv
// Shared constants for the UART receive FIFO: default bus addresses, depth,
// status register layout and the code returned by a data read on an empty FIFO.
package uart_pkg;

  localparam logic [31:0] DEF_DATA_ADDR   = 32'hcafe_bab0;
  localparam logic [31:0] DEF_STAT_ADDR   = 32'hcafe_bab4;
  localparam int          DEF_DEPTH       = 16;

  localparam int          STAT_EMPTY_BIT  = 16;
  localparam int          STAT_FULL_BIT   = 17;
  localparam int          STAT_OVF_BIT    = 18;
  localparam logic [31:0] EMPTY_READ_CODE = 32'h0000_0100;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_DATA = 2'd1,
    ACC_STAT = 2'd2
  } acc_e;

  // Count occupies bits [8:0], wide enough for DEPTH up to 256.
  function automatic logic [31:0] pack_status(input logic [8:0] count,
                                              input logic       empty,
                                              input logic       full,
                                              input logic       ovf);
    logic [31:0] v_stat;
    v_stat                 = 32'h0;
    v_stat[8:0]            = count;
    v_stat[STAT_EMPTY_BIT] = empty;
    v_stat[STAT_FULL_BIT]  = full;
    v_stat[STAT_OVF_BIT]   = ovf;
    return v_stat;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with occupancy count. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [7:0]       i_data,
  input  logic             i_pop,
  output logic [7:0]       o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Pointers are exactly log2(DEPTH) bits, so wrap-around is the natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = w_empty;
  assign o_full  = w_full;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with a two-register CPU read port (data, status), a level
// interrupt while data is pending and a sticky overflow flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter logic [31:0] DATA_ADDR = DEF_DATA_ADDR,
  parameter logic [31:0] STAT_ADDR = DEF_STAT_ADDR,
  parameter int          DEPTH     = DEF_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        mem_valid,
  input  logic [31:0] addr,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        fifo_ready,
  output logic        fifo_int_flag,
  output logic        overflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Bus handshake: a read is served once per mem_valid assertion. The access
  // is detected in the first cycle mem_valid/ren/address match; fifo_ready and
  // rdata appear together one cycle later for exactly one cycle. Further cycles
  // of the same assertion are ignored until mem_valid drops.

  logic [7:0]       w_head;
  logic [CNT_W-1:0] w_count;
  logic [8:0]       w_count_ext;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_drop;
  acc_e             w_acc;

  logic             r_served;
  logic             r_ovf;
  logic             r_ready;
  logic [31:0]      r_rdata;

  always_comb begin
    w_acc = ACC_NONE;
    if (mem_valid && ren && !r_served) begin
      if (addr == DATA_ADDR)      w_acc = ACC_DATA;
      else if (addr == STAT_ADDR) w_acc = ACC_STAT;
    end
  end

  assign w_pop       = (w_acc == ACC_DATA) && !w_empty;
  assign w_drop      = rx_valid && w_full && !w_pop;
  assign w_count_ext = 9'(w_count);

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (rx_valid),
    .i_data  (rx_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_served <= 1'b0;
      r_ovf    <= 1'b0;
      r_ready  <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      r_ready <= (w_acc != ACC_NONE);

      if (!mem_valid)               r_served <= 1'b0;
      else if (w_acc != ACC_NONE)   r_served <= 1'b1;

      // A drop in the same cycle as a status read keeps the flag set.
      if (w_drop)                   r_ovf <= 1'b1;
      else if (w_acc == ACC_STAT)   r_ovf <= 1'b0;

      case (w_acc)
        ACC_DATA: r_rdata <= w_empty ? EMPTY_READ_CODE : {24'h0, w_head};
        ACC_STAT: r_rdata <= pack_status(w_count_ext, w_empty, w_full, r_ovf);
        default:  r_rdata <= r_rdata;
      endcase
    end
  end

  assign rdata         = r_rdata;
  assign fifo_ready    = r_ready;
  assign overflow      = r_ovf;
  assign fifo_int_flag = !w_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table, corner-case sequences and a
// randomized phase checked against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam logic [31:0] DA = 32'hcafe_bab0;
  localparam logic [31:0] SA = 32'hcafe_bab4;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_valid;
  logic [31:0] addr;
  logic        ren;
  logic [31:0] rdata;
  logic        fifo_ready;
  logic        fifo_int_flag;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic       m_ovf;

  uart_rx_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .mem_valid     (mem_valid),
    .addr          (addr),
    .ren           (ren),
    .rdata         (rdata),
    .fifo_ready    (fifo_ready),
    .fifo_int_flag (fifo_int_flag),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue and an overflow bit.
  task automatic model_read(input logic is_stat, output logic [31:0] e);
    if (is_stat) begin
      e = 32'h0;
      e[8:0] = 9'(exp_q.size());
      e[16]  = (exp_q.size() == 0);
      e[17]  = (exp_q.size() == DEPTH);
      e[18]  = m_ovf;
      m_ovf  = 1'b0;
    end else if (exp_q.size() == 0) begin
      e = 32'h0000_0100;
    end else begin
      e = {24'h0, exp_q.pop_front()};
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else                      m_ovf = 1'b1;
  endtask

  task automatic check_flags();
    check("int_flag", {31'h0, fifo_int_flag}, {31'h0, exp_q.size() != 0});
    check("overflow", {31'h0, overflow}, {31'h0, m_ovf});
  endtask

  task automatic do_reset(input logic junk);
    rst = 1'b1; rx_valid = junk; rx_data = 8'h77;
    mem_valid = junk; ren = junk; addr = DA;
    @(posedge clk); #1;
    rst = 1'b0; rx_valid = 1'b0; mem_valid = 1'b0; ren = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    check("rst_ready", {31'h0, fifo_ready}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check_flags();
  endtask

  task automatic do_push(input logic [7:0] b);
    model_push(b);
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check_flags();
  endtask

  // Read held for 'hold' cycles, optionally with a coincident rx push.
  task automatic do_read(input logic is_stat, input int hold, input logic push_en,
                         input logic [7:0] pb, output logic [31:0] rd);
    logic [31:0] e;
    int pulses;
    model_read(is_stat, e);
    if (push_en) model_push(pb);
    mem_valid = 1'b1; ren = 1'b1; addr = is_stat ? SA : DA;
    rx_valid = push_en; rx_data = pb;
    pulses = 0; rd = 32'hdead_beef;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
      if (fifo_ready) begin pulses++; rd = rdata; end
    end
    mem_valid = 1'b0; ren = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (fifo_ready) pulses++;
    end
    check(is_stat ? "stat_rdata" : "data_rdata", rd, e);
    check("ready_pulses", 32'(pulses), 32'd1);
    check("rdata_hold", rdata, rd);
    check_flags();
  endtask

  task automatic ignored(input logic [31:0] a, input logic r);
    int pulses;
    pulses = 0;
    mem_valid = 1'b1; ren = r; addr = a;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (fifo_ready) pulses++;
    end
    mem_valid = 1'b0; ren = 1'b0;
    @(posedge clk); #1;
    if (fifo_ready) pulses++;
    check("ignored_ready", 32'(pulses), 32'd0);
    check_flags();
  endtask

  typedef struct {
    logic [1:0]  op;       // 0 push, 1 data read, 2 status read
    logic [7:0]  din;
    logic [31:0] exp_rd;
    logic        exp_int;
  } vec_t;

  vec_t        tbl[8];
  logic [31:0] rd;
  int          r;

  initial begin
    tbl[0] = '{2'd2, 8'h00, 32'h0001_0000, 1'b0};
    tbl[1] = '{2'd0, 8'haf, 32'h0,         1'b1};
    tbl[2] = '{2'd0, 8'hee, 32'h0,         1'b1};
    tbl[3] = '{2'd2, 8'h00, 32'h0000_0002, 1'b1};
    tbl[4] = '{2'd1, 8'h00, 32'h0000_00af, 1'b1};
    tbl[5] = '{2'd1, 8'h00, 32'h0000_00ee, 1'b0};
    tbl[6] = '{2'd1, 8'h00, 32'h0000_0100, 1'b0};
    tbl[7] = '{2'd2, 8'h00, 32'h0001_0000, 1'b0};

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h0;
    mem_valid = 1'b0; ren = 1'b0; addr = 32'h0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].op == 2'd0) do_push(tbl[i].din);
      else begin
        do_read(tbl[i].op == 2'd2, 1, 1'b0, 8'h0, rd);
        check("tbl_rdata", rd, tbl[i].exp_rd);
      end
      check("tbl_int", {31'h0, fifo_int_flag}, {31'h0, tbl[i].exp_int});
    end

    // Overfill by one, overflow then clear, drain across pointer wrap.
    do_reset(1'b0);
    for (int i = 0; i <= 16; i++) do_push(8'(i));
    do_read(1'b1, 1, 1'b0, 8'h0, rd);  check("fill_stat1", rd, 32'h0006_0010);
    do_read(1'b1, 1, 1'b0, 8'h0, rd);  check("fill_stat2", rd, 32'h0002_0010);
    for (int i = 0; i < 16; i++) begin
      do_read(1'b0, 1, 1'b0, 8'h0, rd);
      check("drain", rd, 32'(i));
    end
    do_push(8'h42);
    do_read(1'b0, 1, 1'b0, 8'h0, rd);  check("wrap_data", rd, 32'h0000_0042);

    // Long mem_valid assertion is served once.
    do_reset(1'b0);
    do_push(8'h5a); do_push(8'h5b);
    do_read(1'b0, 5, 1'b0, 8'h0, rd);  check("hold5_data", rd, 32'h0000_005a);
    do_read(1'b1, 1, 1'b0, 8'h0, rd);  check("hold5_stat", rd, 32'h0000_0001);

    // Push and pop together on an empty FIFO: no bypass.
    do_reset(1'b0);
    do_read(1'b0, 1, 1'b1, 8'h3c, rd); check("empty_pp", rd, 32'h0000_0100);
    do_read(1'b1, 1, 1'b0, 8'h0, rd);  check("empty_pp_stat", rd, 32'h0000_0001);
    do_read(1'b0, 1, 1'b0, 8'h0, rd);  check("empty_pp_data", rd, 32'h0000_003c);

    // Push and pop together on a full FIFO, then reset mid-sequence.
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) do_push(8'(8'h10 + i));
    do_read(1'b0, 1, 1'b1, 8'h99, rd); check("full_pp", rd, 32'h0000_0010);
    do_read(1'b1, 1, 1'b0, 8'h0, rd);  check("full_pp_stat", rd, 32'h0002_0010);
    for (int i = 1; i < 16; i++) begin
      do_read(1'b0, 1, 1'b0, 8'h0, rd);
      check("full_pp_drain", rd, 32'(8'h10 + i));
    end
    do_read(1'b0, 1, 1'b0, 8'h0, rd);  check("full_pp_last", rd, 32'h0000_0099);
    do_push(8'h01); do_push(8'h02); do_push(8'h03);
    do_reset(1'b1);
    do_read(1'b1, 1, 1'b0, 8'h0, rd);  check("mid_rst_stat", rd, 32'h0001_0000);

    // Overflow event coinciding with the clearing status read.
    for (int i = 0; i < 16; i++) do_push(8'(i));
    do_push(8'ha0);
    do_read(1'b1, 1, 1'b1, 8'ha1, rd); check("ovf_race1", rd, 32'h0006_0010);
    do_read(1'b1, 1, 1'b0, 8'h0, rd);  check("ovf_race2", rd, 32'h0006_0010);
    do_read(1'b1, 1, 1'b0, 8'h0, rd);  check("ovf_race3", rd, 32'h0002_0010);

    // Writes and foreign addresses are ignored.
    ignored(DA, 1'b0);
    ignored(SA, 1'b0);
    ignored(32'hcafe_bab8, 1'b1);
    do_read(1'b1, 1, 1'b0, 8'h0, rd);  check("ignored_stat", rd, 32'h0002_0010);

    // Randomized traffic against the model.
    do_reset(1'b0);
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      do_push(8'($urandom));
      else if (r <= 5) do_read(1'b0, $urandom_range(1, 3), 1'b0, 8'h0, rd);
      else if (r == 6) do_read(1'b1, 1, 1'b0, 8'h0, rd);
      else if (r == 7) do_read(1'b0, 1, 1'b1, 8'($urandom), rd);
      else if (r == 8) do_read(1'b1, 1, 1'b1, 8'($urandom), rd);
      else             ignored($urandom_range(0, 1) ? DA : 32'h1234_5678, $urandom_range(0, 1) == 1 ? 1'b0 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_ADDR, default 32'hcafe_bab0: bus address of the data register.
REQ-002 Parameter STAT_ADDR, default 32'hcafe_bab4: bus address of the status register.
REQ-003 Parameter DEPTH, default 16: FIFO entries, power of two, range 2..256.
REQ-004 Port clk  in  1: single clock, all logic on its rising edge.
REQ-005 Port rst  in  1: synchronous, active-high reset.
REQ-006 Port rx_valid  in  1: one-cycle strobe from the UART receiver; a byte is available.
REQ-007 Port rx_data  in  8: received byte, valid when rx_valid=1.
REQ-008 Port mem_valid  in  1: CPU bus request valid.
REQ-009 Port addr  in  32: CPU bus address.
REQ-010 Port ren  in  1: read strobe; 1 = read access.
REQ-011 Port rdata  out  32: read data returned to the CPU.
REQ-012 Port fifo_ready  out  1: one-cycle acknowledge that this block served the access.
REQ-013 Port fifo_int_flag  out  1: level interrupt; 1 while the FIFO is non-empty.
REQ-014 Port overflow  out  1: sticky flag; a byte was dropped because the FIFO was full.

Function
REQ-015 Push: rx_valid=1 and (not full, or a pop in the same cycle) writes rx_data at the write pointer, and count increments (unchanged if popping).
REQ-016 Drop: rx_valid=1 while full with no same-cycle pop discards the byte and sets overflow; contents and count are unchanged.
REQ-017 Access detect: mem_valid=1, ren=1, addr equal to DATA_ADDR or STAT_ADDR, and served=0.
REQ-018 served is set on a detected access and cleared in any cycle with mem_valid=0, giving exactly one service per mem_valid assertion.
REQ-019 rdata and fifo_ready are registered: both are valid in the cycle after detection, and fifo_ready is high for exactly one cycle.
REQ-020 Data read, non-empty: rdata = {24'h0, head byte}; the head is popped in the detection cycle.
REQ-021 Data read, empty: rdata = 32'h0000_0100 (bit 8 = empty); no pop occurs.
REQ-022 Status read: rdata[8:0]=count, [16]=empty, [17]=full, [18]=overflow, other bits 0; no pop occurs.
REQ-023 A status read clears overflow in the detection cycle; an overflow event in that same cycle wins, leaving overflow=1.
REQ-024 Push and pop in the same cycle on an empty FIFO: the read reports empty (no bypass), and the push is accepted (count becomes 1).
REQ-025 Push and pop in the same cycle on a full FIFO: both proceed; count stays DEPTH; no overflow.
REQ-026 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-027 empty = (count==0); full = (count==DEPTH); fifo_int_flag = !empty, combinational from count.
REQ-028 Writes (ren=0) and non-matching addresses are ignored: no fifo_ready, no state change.
REQ-029 rdata holds its last value when fifo_ready=0.

Reset
REQ-030 With rst=1 at a clock edge, the block clears: pointers, count, overflow, served, fifo_ready to 0, and rdata to 32'h0.
REQ-031 Reset mid-operation discards all stored bytes; a push or access in the reset cycle is ignored.
REQ-032 Storage array contents are not reset.

Structure
REQ-033 A shared package uart_pkg holds DATA_ADDR/STAT_ADDR defaults, the DEPTH default, status bit positions and the empty-read code 32'h0000_0100.
REQ-034 Storage and pointers go in one sub-module, sync_fifo (push/pop/full/empty/count).
REQ-035 The bus decode and the served/overflow logic stay in uart_rx_fifo.

Verification
REQ-036 Reset, then status read -> rdata=32'h0001_0000, fifo_int_flag=0, overflow=0.
REQ-037 Push 8'haf then 8'hee; two data reads -> 32'h0000_00af then 32'h0000_00ee; fifo_int_flag falls after the second pop.
REQ-038 Data read on empty FIFO -> rdata=32'h0000_0100; count stays 0; fifo_ready high exactly 1 cycle.
REQ-039 Push 17 bytes 0x00..0x10 with DEPTH=16 -> status 32'h0006_0010 (full, overflow, count 16); second status read -> overflow cleared; 16 data reads return 0x00..0x0F; write pointer has wrapped.
REQ-040 mem_valid held high 5 cycles on DATA_ADDR -> single pop, single fifo_ready pulse.
REQ-041 Full FIFO, rx_valid coincident with a data-read detect -> count remains 16, no overflow, new byte read last; rst asserted mid-sequence -> status reads 32'h0001_0000.
